// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between a byte producer, the TX feeder and a UART transmitter.
// The slave modport is the feeder's view; master is the producer/transmitter side.
interface uart_tx_feeder_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic          i_Wr_En;
  logic [7:0]    i_Wr_Byte;
  logic          i_Clr_Ovf;
  logic          o_Full;
  logic          o_Empty;
  logic [AW:0]   o_Count;
  logic          o_Overflow;
  logic          o_Busy;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          i_Tx_Active;
  logic          i_Tx_Done;

  modport slave (
    input  i_Wr_En, i_Wr_Byte, i_Clr_Ovf, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
  );

  modport master (
    output i_Wr_En, i_Wr_Byte, i_Clr_Ovf, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter one byte at a time, pacing each
// start pulse on the transmitter's active/done handshake.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  uart_tx_feeder_if.slave bus
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          avail_q;
  logic          overflow;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = bus.i_Wr_En && !full;
  // The FSM acts on a one-cycle-old availability flag, so a freshly written
  // byte is popped two edges after its write.
  assign pop   = (state == IDLE) && avail_q && !empty;

  // Storage is never reset; only pointers and count define its contents.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= bus.i_Wr_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      avail_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      avail_q <= !empty;
    end
  end

  // A write attempted while full outranks a coincident clear.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      overflow <= 1'b0;
    end else if (bus.i_Wr_En && full) begin
      overflow <= 1'b1;
    end else if (bus.i_Clr_Ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_byte <= mem[rd_ptr];
            tx_dv   <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE:     state <= WAIT_ACT;
        WAIT_ACT:  if (bus.i_Tx_Active) state <= WAIT_DONE;
        WAIT_DONE: if (bus.i_Tx_Done)   state <= GAP;
        // Done may linger; hold here so no new byte starts until it drops.
        GAP:       if (!bus.i_Tx_Done)  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign bus.o_Full     = full;
  assign bus.o_Empty    = empty;
  assign bus.o_Count    = count;
  assign bus.o_Overflow = overflow;
  assign bus.o_Busy     = !empty || (state != IDLE);
  assign bus.o_Tx_DV    = tx_dv;
  assign bus.o_Tx_Byte  = tx_byte;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench: feeder paired with a behavioural UART transmitter
// (4 clocks per bit) and a serial-line receiver that collects frames.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic i_Clock = 1'b0;
  logic i_Rst_n;
  always #5 i_Clock = ~i_Clock;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_feeder #(.DEPTH(DEPTH)) dut (.i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Transmitter model
  int         tx_st = 0;
  int         tx_cnt = 0;
  int         tx_bit = 0;
  int         tx_dcnt = 0;
  int         done_len = 1;
  logic [8:0] tx_sh;
  logic       tx_ser;
  logic       tx_act;
  logic       tx_done;

  assign bus.i_Tx_Active = tx_act;
  assign bus.i_Tx_Done   = tx_done;

  always @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_st <= 0; tx_cnt <= 0; tx_bit <= 0; tx_dcnt <= 0;
      tx_sh <= '0; tx_ser <= 1'b1; tx_act <= 1'b0; tx_done <= 1'b0;
    end else begin
      case (tx_st)
        0: if (bus.o_Tx_DV) begin
             tx_sh <= {1'b1, bus.o_Tx_Byte};
             tx_ser <= 1'b0; tx_act <= 1'b1;
             tx_cnt <= 0; tx_bit <= 0; tx_st <= 1;
           end
        1: if (tx_cnt == CPB-1) begin
             tx_cnt <= 0;
             if (tx_bit == 9) begin
               tx_act <= 1'b0; tx_done <= 1'b1; tx_dcnt <= 1; tx_st <= 2; tx_ser <= 1'b1;
             end else begin
               tx_ser <= tx_sh[0]; tx_sh <= tx_sh >> 1; tx_bit <= tx_bit + 1;
             end
           end else begin
             tx_cnt <= tx_cnt + 1;
           end
        default: if (tx_dcnt >= done_len) begin
                   tx_done <= 1'b0; tx_st <= 0;
                 end else begin
                   tx_dcnt <= tx_dcnt + 1;
                 end
      endcase
    end
  end

  // Serial receiver: samples two clocks into each bit, frame bit 0 = start bit
  logic       rx_busy;
  logic [1:0] rx_cnt;
  int         rx_idx;
  logic [9:0] rx_sh;
  logic [9:0] rx_q [$];

  always @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_busy <= 1'b0; rx_cnt <= 2'd0; rx_idx <= 0; rx_sh <= '0;
    end else if (!rx_busy) begin
      if (!tx_ser) begin
        rx_busy <= 1'b1; rx_cnt <= 2'd1; rx_idx <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 2'd1;
      if (rx_cnt == 2'd1) begin
        if (rx_idx == 9) begin
          rx_q.push_back({tx_ser, rx_sh[9:1]});
          rx_busy <= 1'b0;
        end else begin
          rx_sh  <= {tx_ser, rx_sh[9:1]};
          rx_idx <= rx_idx + 1;
        end
      end
    end
  end

  int dv_cnt = 0;
  int dv_bad = 0;
  always @(posedge i_Clock) begin
    if (bus.o_Tx_DV) dv_cnt <= dv_cnt + 1;
    if (bus.o_Tx_DV && tx_done) dv_bad <= dv_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic wr(input logic [7:0] b);
    bus.i_Wr_Byte = b;
    bus.i_Wr_En   = 1'b1;
    @(negedge i_Clock);
    bus.i_Wr_En   = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int max);
    int i = 0;
    while (!bus.o_Tx_DV && i < max) begin @(negedge i_Clock); i++; end
    chk(tag, 32'(bus.o_Tx_DV), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int i = 0;
    while ((bus.o_Busy || rx_busy || tx_st != 0) && i < max) begin @(negedge i_Clock); i++; end
    chk(tag, 32'(bus.o_Busy | rx_busy | (tx_st != 0)), 32'd0);
  endtask

  // Returns at the negedge right after the FSM's pop edge that follows a done pulse.
  task automatic sync_pop(input logic do_wr, input logic [7:0] b);
    int i = 0;
    while (!tx_done && i < 200) begin @(negedge i_Clock); i++; end
    chk("sync_done_hi", 32'(tx_done), 32'd1);
    i = 0;
    while (tx_done && i < 20) begin @(negedge i_Clock); i++; end
    chk("sync_done_lo", 32'(tx_done), 32'd0);
    @(negedge i_Clock);
    bus.i_Wr_Byte = b;
    bus.i_Wr_En   = do_wr;
    @(negedge i_Clock);
    bus.i_Wr_En   = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] b);
    logic [9:0] f = 10'h000;
    if (rx_q.size() != 0) f = rx_q.pop_front();
    chk(tag, 32'(f), 32'({1'b1, b, 1'b0}));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(bus.o_Empty),    32'd1);
    chk({tag, "_full"},  32'(bus.o_Full),     32'd0);
    chk({tag, "_count"}, 32'(bus.o_Count),    32'd0);
    chk({tag, "_ovf"},   32'(bus.o_Overflow), 32'd0);
    chk({tag, "_busy"},  32'(bus.o_Busy),     32'd0);
    chk({tag, "_dv"},    32'(bus.o_Tx_DV),    32'd0);
    chk({tag, "_byte"},  32'(bus.o_Tx_Byte),  32'h00);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int b0;
    logic [9:0] f;
    bus.i_Wr_En = 1'b0; bus.i_Wr_Byte = 8'h00; bus.i_Clr_Ovf = 1'b0;
    i_Rst_n = 1'b0;
    cyc(3);
    chk_reset_vals("rst");
    i_Rst_n = 1'b1;
    cyc(2);

    // Single byte: latency and serial framing
    d0 = dv_cnt;
    bus.i_Wr_Byte = 8'hA5; bus.i_Wr_En = 1'b1;
    @(negedge i_Clock); bus.i_Wr_En = 1'b0;
    chk("lat_k_dv",    32'(bus.o_Tx_DV), 32'd0);
    chk("lat_k_count", 32'(bus.o_Count), 32'd1);
    chk("lat_k_busy",  32'(bus.o_Busy),  32'd1);
    @(negedge i_Clock);
    chk("lat_k1_dv",   32'(bus.o_Tx_DV), 32'd0);
    @(negedge i_Clock);
    chk("lat_k2_dv",   32'(bus.o_Tx_DV), 32'd1);
    chk("lat_k2_byte", 32'(bus.o_Tx_Byte), 32'hA5);
    chk("lat_k2_empty", 32'(bus.o_Empty), 32'd1);
    @(negedge i_Clock);
    chk("lat_k3_dv",   32'(bus.o_Tx_DV), 32'd0);
    chk("hold_byte",   32'(bus.o_Tx_Byte), 32'hA5);
    wait_idle("single_idle", 400);
    f = 10'h000;
    if (rx_q.size() != 0) f = rx_q.pop_front();
    chk("single_frame", 32'(f), 32'h34A);
    chk("single_dvs", 32'(dv_cnt - d0), 32'd1);
    chk("single_busy", 32'(bus.o_Busy), 32'd0);

    // Burst of four into the FIFO while a first byte is in flight
    d0 = dv_cnt;
    wr(8'h10);
    wait_dv("burst_dv0", 20);
    cyc(1);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    chk("burst_full",  32'(bus.o_Full),  32'd1);
    chk("burst_count", 32'(bus.o_Count), 32'd4);
    wait_idle("burst_idle", 1500);
    chk_frame("burst_f0", 8'h10);
    chk_frame("burst_f1", 8'h01);
    chk_frame("burst_f2", 8'h02);
    chk_frame("burst_f3", 8'h03);
    chk_frame("burst_f4", 8'h04);
    chk("burst_dvs", 32'(dv_cnt - d0), 32'd5);
    chk("burst_ovf", 32'(bus.o_Overflow), 32'd0);
    chk("burst_extra", 32'(rx_q.size()), 32'd0);

    // Overflow, clear priority, and push/pop on the same edge
    d0 = dv_cnt;
    wr(8'h20);
    wait_dv("ovf_dv0", 20);
    cyc(1);
    wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34);
    chk("ovf_pre", 32'(bus.o_Overflow), 32'd0);
    wr(8'h35);
    chk("ovf_set",   32'(bus.o_Overflow), 32'd1);
    chk("ovf_count", 32'(bus.o_Count),    32'd4);
    bus.i_Clr_Ovf = 1'b1; @(negedge i_Clock); bus.i_Clr_Ovf = 1'b0;
    chk("ovf_clr", 32'(bus.o_Overflow), 32'd0);
    bus.i_Clr_Ovf = 1'b1; wr(8'h36); bus.i_Clr_Ovf = 1'b0;
    chk("ovf_wins_clr", 32'(bus.o_Overflow), 32'd1);
    bus.i_Clr_Ovf = 1'b1; @(negedge i_Clock); bus.i_Clr_Ovf = 1'b0;
    chk("ovf_clr2", 32'(bus.o_Overflow), 32'd0);
    sync_pop(1'b1, 8'h3F);
    chk("pp4_count", 32'(bus.o_Count),    32'd3);
    chk("pp4_ovf",   32'(bus.o_Overflow), 32'd1);
    chk("pp4_dv",    32'(bus.o_Tx_DV),    32'd1);
    chk("pp4_byte",  32'(bus.o_Tx_Byte),  32'h31);
    sync_pop(1'b0, 8'h00);
    chk("pop3_count", 32'(bus.o_Count),   32'd2);
    chk("pop3_byte",  32'(bus.o_Tx_Byte), 32'h32);
    sync_pop(1'b1, 8'h4E);
    chk("pp2_count", 32'(bus.o_Count),   32'd2);
    chk("pp2_byte",  32'(bus.o_Tx_Byte), 32'h33);
    wait_idle("ovf_idle", 1500);
    chk_frame("ovf_f0", 8'h20);
    chk_frame("ovf_f1", 8'h31);
    chk_frame("ovf_f2", 8'h32);
    chk_frame("ovf_f3", 8'h33);
    chk_frame("ovf_f4", 8'h34);
    chk_frame("ovf_f5", 8'h4E);
    chk("ovf_extra", 32'(rx_q.size()), 32'd0);
    chk("ovf_dvs", 32'(dv_cnt - d0), 32'd6);

    // Reset mid-frame with three bytes queued
    wr(8'h55);
    wait_dv("rstmid_dv0", 20);
    cyc(1);
    wr(8'h61); wr(8'h62); wr(8'h63);
    chk("rstmid_count", 32'(bus.o_Count), 32'd3);
    cyc(8);
    i_Rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid");
    cyc(2);
    i_Rst_n = 1'b1;
    rx_q.delete();
    d0 = dv_cnt;
    cyc(100);
    chk("rstmid_nodv",  32'(dv_cnt - d0), 32'd0);
    chk("rstmid_busy",  32'(bus.o_Busy),  32'd0);
    chk("rstmid_nofrm", 32'(rx_q.size()), 32'd0);
    wr(8'h77);
    wait_idle("rstmid_idle", 400);
    chk_frame("rstmid_f0", 8'h77);
    chk("rstmid_dvs", 32'(dv_cnt - d0), 32'd1);

    // Done held high for two cycles
    done_len = 2;
    d0 = dv_cnt;
    b0 = dv_bad;
    wr(8'h88); wr(8'h99);
    wait_idle("done2_idle", 600);
    chk_frame("done2_f0", 8'h88);
    chk_frame("done2_f1", 8'h99);
    chk("done2_dvs",   32'(dv_cnt - d0), 32'd2);
    chk("done2_nodv",  32'(dv_bad - b0), 32'd0);
    chk("done2_busy",  32'(bus.o_Busy),  32'd0);
    chk("done2_extra", 32'(rx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default $clog2(DEPTH): FIFO address width, derived; SHALL NOT be overridden.
REQ-003 i_Clock  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_Rst_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 i_Wr_En  in  1  write strobe; a byte is pushed on any edge with i_Wr_En=1 and o_Full=0.
REQ-006 i_Wr_Byte  in  8  byte to push.
REQ-007 i_Clr_Ovf  in  1  clears the sticky o_Overflow flag.
REQ-008 o_Full  out  1  FIFO holds DEPTH bytes.
REQ-009 o_Empty  out  1  FIFO holds 0 bytes.
REQ-010 o_Count  out  AW+1  bytes currently stored.
REQ-011 o_Overflow  out  1  sticky flag: a write was attempted while full.
REQ-012 o_Busy  out  1  high while FIFO is non-empty or FSM is not in IDLE.
REQ-013 o_Tx_DV  out  1  one-cycle start pulse to the UART transmitter.
REQ-014 o_Tx_Byte  out  8  byte for the transmitter; valid while o_Tx_DV=1, held stable afterwards.
REQ-015 i_Tx_Active  in  1  transmitter busy indication.
REQ-016 i_Tx_Done  in  1  transmitter completion indication (may stay high for more than one cycle).

Function
REQ-017 FIFO: circular buffer with AW-bit read/write pointers wrapping DEPTH-1 -> 0; count register AW+1 bits; o_Full=(count==DEPTH), o_Empty=(count==0).
REQ-018 Write while full SHALL be dropped and set o_Overflow, even if a pop occurs on the same edge.
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 i_Clr_Ovf=1 SHALL clear o_Overflow next edge; a coincident overflowing write SHALL win (flag stays 1).
REQ-021 FSM states: IDLE, ISSUE, WAIT_ACT, WAIT_DONE, GAP.
REQ-022 IDLE: if FIFO non-empty, pop head into o_Tx_Byte, go to ISSUE; else stay.
REQ-023 ISSUE: o_Tx_DV=1 for exactly this one cycle; go to WAIT_ACT.
REQ-024 WAIT_ACT: stay until i_Tx_Active=1, then go to WAIT_DONE.
REQ-025 WAIT_DONE: stay until i_Tx_Done=1, then go to GAP.
REQ-026 GAP: stay until i_Tx_Done=0, then go to IDLE; no new DV SHALL be issued while i_Tx_Done=1.
REQ-027 Latency: byte written on edge k into an empty FIFO with FSM in IDLE SHALL produce o_Tx_DV=1 in the cycle after edge k+2.
REQ-028 Bytes SHALL be issued in write order, one o_Tx_DV pulse per accepted byte, none otherwise.
REQ-029 o_Tx_DV SHALL be 0 in every state except ISSUE.
REQ-030 Illegal FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-031 While i_Rst_n=0: FSM=IDLE, pointers and count=0, o_Empty=1, o_Full=0, o_Count=0, o_Overflow=0, o_Busy=0, o_Tx_DV=0, o_Tx_Byte=8'h00; FIFO storage need not be cleared.
REQ-032 Reset asserted mid-transfer SHALL discard all queued bytes; after release, the FSM SHALL issue nothing until a new write.

Verification (bench pairs DUT with the UART transmitter, CLKS_PER_BIT=4, DEPTH=4)
REQ-033 Single byte: write 8'hA5 at edge k -> o_Tx_DV pulse after edge k+2, serial line 0,1,0,1,0,0,1,0,1,1 (LSB first), o_Busy=0 after Done falls.
REQ-034 Burst: write 8'h01,8'h02,8'h03,8'h04 back-to-back -> o_Full=1, o_Count=4; serial frames 01,02,03,04 in order, exactly four DV pulses.
REQ-035 Overflow: five writes without drain -> fifth dropped, o_Overflow=1; i_Clr_Ovf pulse -> o_Overflow=0; a 5th-byte frame is never sent.
REQ-036 Push/pop same edge at o_Count=4 with write -> write dropped, o_Count=3, o_Overflow=1; at o_Count=2 -> o_Count stays 2.
REQ-037 Reset mid-frame with 3 bytes queued -> all outputs at reset values, no DV after release until a new write.
REQ-038 Done held high 2 cycles -> exactly one transition GAP->IDLE, no DV while i_Tx_Done=1.
